suspicion_alert_ctrl: RTL and testbench

//  Alarm stage directly downstream of obj_det_unit_top. Qualifies object_susp over

---
 rtl/suspicion_alert_ctrl.sv | 157 +++++++++++++++
 tb/tb_suspicion_alert_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/suspicion_alert_ctrl.sv
// rtl/suspicion_alert_ctrl.sv - frame-qualified suspicion alarm with blinking LED, buzzer and event counter
// Optional macro ALERT_BUZZER_EN adds the buzzer tone generator; otherwise buzzer_out is tied low.
module suspicion_alert_ctrl #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BLINK_HZ       = 2,
  parameter int TONE_HZ        = 2000,
  parameter int CONFIRM_FRAMES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ov7670_vsync,
  input  logic       object_detected,
  input  logic       object_susp,
  input  logic       ack,
  output logic       alert_active,
  output logic       alert_led,
  output logic       buzzer_out,
  output logic [7:0] alert_events,
  output logic [1:0] state_dbg
);

  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int CW         = $clog2(CONFIRM_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALERT = 2'd2,
    ACKED = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   confirm_cnt, confirm_nxt;
  logic            vsync_meta, vsync_sync, vsync_prev, frame_tick;
  logic            ack_meta, ack_sync, ack_prev, ack_pulse;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;
  logic            alert_entry;

  // Both asynchronous inputs go through two flops before edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vsync_meta <= 1'b0;
      vsync_sync <= 1'b0;
      vsync_prev <= 1'b0;
      frame_tick <= 1'b0;
      ack_meta   <= 1'b0;
      ack_sync   <= 1'b0;
      ack_prev   <= 1'b0;
      ack_pulse  <= 1'b0;
    end else begin
      vsync_meta <= ov7670_vsync;
      vsync_sync <= vsync_meta;
      vsync_prev <= vsync_sync;
      frame_tick <= vsync_sync & ~vsync_prev;
      ack_meta   <= ack;
      ack_sync   <= ack_meta;
      ack_prev   <= ack_sync;
      ack_pulse  <= ack_sync & ~ack_prev;
    end
  end

  always_comb begin
    confirm_nxt = confirm_cnt;
    if (!object_susp) begin
      confirm_nxt = '0;
    end else if (frame_tick && (confirm_cnt != CW'(CONFIRM_FRAMES))) begin
      confirm_nxt = confirm_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (object_detected) state_nxt = ARMED;
      ARMED: begin
        if (confirm_nxt == CW'(CONFIRM_FRAMES)) begin
          state_nxt = ALERT;
        end else if (!object_detected && !object_susp) begin
          state_nxt = IDLE;
        end
      end
      ALERT:   if (ack_pulse) state_nxt = ACKED;
      ACKED:   if (frame_tick && !object_susp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign alert_entry = (state == ARMED) && (state_nxt == ALERT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      confirm_cnt  <= '0;
      alert_events <= 8'd0;
      state_dbg    <= 2'd0;
      alert_active <= 1'b0;
      alert_led    <= 1'b0;
    end else begin
      state       <= state_nxt;
      confirm_cnt <= confirm_nxt;
      if (alert_entry && (alert_events != 8'hFF)) begin
        alert_events <= alert_events + 8'd1;
      end
      state_dbg    <= state;
      alert_active <= (state == ALERT);
      alert_led    <= (state == ALERT) ? ~blink_phase : (state == ACKED);
    end
  end

  // Counters sit at zero outside ALERT, so entry always starts a fresh period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (state != ALERT) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

`ifdef ALERT_BUZZER_EN
  localparam int TONE_HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int TW        = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  logic [TW-1:0] tone_cnt;
  logic          tone_phase;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tone_cnt   <= '0;
      tone_phase <= 1'b0;
      buzzer_out <= 1'b0;
    end else begin
      buzzer_out <= (state == ALERT) & tone_phase;
      if (state != ALERT) begin
        tone_cnt   <= '0;
        tone_phase <= 1'b0;
      end else if (tone_cnt == TW'(TONE_HALF - 1)) begin
        tone_cnt   <= '0;
        tone_phase <= ~tone_phase;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end
`else
  assign buzzer_out = 1'b0;
`endif

endmodule

// File: tb/tb_suspicion_alert_ctrl.sv
// tb/tb_suspicion_alert_ctrl.sv - directed self-checking bench for suspicion_alert_ctrl
module tb_suspicion_alert_ctrl;

`ifdef ALERT_BUZZER_EN
  localparam bit BUZZ_EN = 1'b1;
`else
  localparam bit BUZZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ov7670_vsync = 1'b0;
  logic       object_detected = 1'b0;
  logic       object_susp = 1'b0;
  logic       ack = 1'b0;
  logic       alert_active;
  logic       alert_led;
  logic       buzzer_out;
  logic [7:0] alert_events;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  suspicion_alert_ctrl #(
    .CLK_HZ(1000),
    .BLINK_HZ(50),
    .TONE_HZ(250),
    .CONFIRM_FRAMES(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ov7670_vsync(ov7670_vsync),
    .object_detected(object_detected),
    .object_susp(object_susp),
    .ack(ack),
    .alert_active(alert_active),
    .alert_led(alert_led),
    .buzzer_out(buzzer_out),
    .alert_events(alert_events),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    ov7670_vsync = 1'b1;
    repeat (4) tick();
    ov7670_vsync = 1'b0;
    repeat (36) tick();
  endtask

  task automatic fast_frame();
    ov7670_vsync = 1'b1;
    repeat (2) tick();
    ov7670_vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic alert_cycle();
    object_detected = 1'b1;
    object_susp = 1'b1;
    repeat (3) fast_frame();
    repeat (3) tick();
    ack = 1'b1;
    repeat (5) tick();
    ack = 1'b0;
    repeat (2) tick();
    object_susp = 1'b0;
    fast_frame();
    repeat (3) tick();
  endtask

  initial begin
    // Reset state
    resetn = 1'b0;
    repeat (3) tick();
    check("rst_active", alert_active, 0);
    check("rst_led", alert_led, 0);
    check("rst_buzz", buzzer_out, 0);
    check("rst_events", alert_events, 0);
    check("rst_state", state_dbg, 0);
    resetn = 1'b1;

    // Three suspicious frames raise the alert
    object_detected = 1'b1;
    object_susp = 1'b1;
    tick();
    check("s1_state_idle", state_dbg, 0);
    tick();
    check("s1_state_armed", state_dbg, 1);
    frame();
    frame();
    check("s1_armed_after2", state_dbg, 1);
    check("s1_noalert_after2", alert_active, 0);
    ov7670_vsync = 1'b1;
    repeat (4) tick();
    ov7670_vsync = 1'b0;
    check("s1_active_early", alert_active, 0);
    tick();
    check("s1_active", alert_active, 1);
    check("s1_state_alert", state_dbg, 2);
    check("s1_events", alert_events, 1);
    check("s1_led0", alert_led, 1);
    check("s1_buzz0", buzzer_out, 0);

    // Blink every 10 clk starting high, tone every 2 clk starting low
    for (int k = 1; k < 30; k++) begin
      tick();
      check($sformatf("s2_led_%0d", k), alert_led, ((k / 10) % 2) == 0);
      check($sformatf("s2_buzz_%0d", k), buzzer_out, BUZZ_EN && (((k / 2) % 2) == 1));
    end

    // Held ack moves to ACKED once
    ack = 1'b1;
    repeat (4) tick();
    check("s4_active_before", alert_active, 1);
    tick();
    check("s4_active_off", alert_active, 0);
    check("s4_state_acked", state_dbg, 3);
    repeat (45) tick();
    check("s4_state_held", state_dbg, 3);
    check("s4_led_steady", alert_led, 1);
    check("s4_buzz_off", buzzer_out, 0);
    ack = 1'b0;
    frame();
    check("s4_no_rearm", state_dbg, 3);
    check("s4_events_same", alert_events, 1);
    object_susp = 1'b0;
    object_detected = 1'b0;
    frame();
    check("s4_state_idle", state_dbg, 0);
    check("s4_led_off", alert_led, 0);
    ack = 1'b1;
    repeat (10) tick();
    ack = 1'b0;
    repeat (3) tick();
    check("s4_ack_idle_state", state_dbg, 0);
    check("s4_ack_idle_events", alert_events, 1);

    // An interrupted run of suspicious frames restarts the count
    object_detected = 1'b1;
    object_susp = 1'b1;
    frame();
    frame();
    object_susp = 1'b0;
    repeat (5) tick();
    object_susp = 1'b1;
    frame();
    frame();
    check("s3_state_armed", state_dbg, 1);
    check("s3_no_alert", alert_active, 0);
    check("s3_events", alert_events, 1);
    ov7670_vsync = 1'b1;
    repeat (4) tick();
    ov7670_vsync = 1'b0;
    check("s3_active_early", alert_active, 0);
    tick();
    check("s3_active", alert_active, 1);
    check("s3_events2", alert_events, 2);
    repeat (3) tick();

    // Asynchronous reset mid-ALERT
    #3;
    resetn = 1'b0;
    object_detected = 1'b0;
    object_susp = 1'b0;
    #1;
    check("s5_active", alert_active, 0);
    check("s5_led", alert_led, 0);
    check("s5_state", state_dbg, 0);
    check("s5_events", alert_events, 0);
    @(posedge clk);
    #4;
    resetn = 1'b1;
    repeat (3) tick();
    check("s5_state_after", state_dbg, 0);
    check("s5_events_after", alert_events, 0);

    // Event counter saturation
    for (int i = 0; i < 254; i++) alert_cycle();
    check("sat_254", alert_events, 254);
    alert_cycle();
    check("sat_255", alert_events, 255);
    alert_cycle();
    check("sat_hold", alert_events, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
